// File: rtl/ex_muldiv_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ex_muldiv_pkg : op codes, FSM states and op-decode helpers         |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package ex_muldiv_pkg;

    localparam logic [2:0] MDU_OP_MULT  = 3'd0;
    localparam logic [2:0] MDU_OP_MULTU = 3'd1;
    localparam logic [2:0] MDU_OP_DIV   = 3'd2;
    localparam logic [2:0] MDU_OP_DIVU  = 3'd3;
    localparam logic [2:0] MDU_OP_MADD  = 3'd4;
    localparam logic [2:0] MDU_OP_MADDU = 3'd5;
    localparam logic [2:0] MDU_OP_MSUB  = 3'd6;
    localparam logic [2:0] MDU_OP_MSUBU = 3'd7;

    typedef enum logic [1:0] {
        MDU_ST_IDLE = 2'd0,
        MDU_ST_MUL  = 2'd1,
        MDU_ST_DIV  = 2'd2,
        MDU_ST_FIX  = 2'd3
    } mdu_state_e;

    // Even codes are the signed variants.
    function automatic logic mdu_is_signed(input logic [2:0] op);
        return ~op[0];
    endfunction

    function automatic logic mdu_is_div(input logic [2:0] op);
        return (op == MDU_OP_DIV) || (op == MDU_OP_DIVU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ex_muldiv_div_core.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mdu_div_core : radix-2 restoring divide step on a rem/quot pair    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module mdu_div_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quot_o
);

    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    always_comb begin
        rem_d   = rem_q;
        quot_d  = quot_q;
        shifted = {rem_q, quot_q[WIDTH-1]};
        trial   = shifted - {1'b0, divisor_i};
        if (load_i) begin
            rem_d  = '0;
            quot_d = dividend_i;
        end else if (step_i) begin
            // Top bit of trial is the borrow: set means the divisor did not fit.
            if (!trial[WIDTH]) begin
                rem_d  = trial[WIDTH-1:0];
                quot_d = {quot_q[WIDTH-2:0], 1'b1};
            end else begin
                rem_d  = shifted[WIDTH-1:0];
                quot_d = {quot_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q  <= '0;
            quot_q <= '0;
        end else begin
            rem_q  <= rem_d;
            quot_q <= quot_d;
        end
    end

    assign rem_o  = rem_q;
    assign quot_o = quot_q;

endmodule
`default_nettype wire

// File: rtl/ex_muldiv.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ex_muldiv : iterative multiply / divide / multiply-accumulate unit |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MUL_BITS = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] opa_i,
    input  logic [WIDTH-1:0] opb_i,
    input  logic [WIDTH-1:0] hi_i,
    input  logic [WIDTH-1:0] lo_i,
    input  logic             annul_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] MUL_LAST = CW'(WIDTH / MUL_BITS - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH - 1);

    mdu_state_e         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2:0]         op_q, op_d;
    logic [WIDTH-1:0]   opa_q, opa_d, opb_q, opb_d;
    logic               sign_a_q, sign_a_d, sign_b_q, sign_b_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, prod_q, prod_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               done_q, done_d;

    logic               accept, a_neg, b_neg;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic               div_load, div_step;
    logic [WIDTH-1:0]   div_rem, div_quot;
    logic [WIDTH+MUL_BITS-1:0] pp_sum, mul_hi;
    logic [2*WIDTH-1:0] mul_next, prod_signed, result;
    logic [WIDTH-1:0]   quot_signed, rem_signed, raw_a;

    assign busy_o = (state_q != MDU_ST_IDLE);
    assign accept = start_i & ~busy_o & ~annul_i;
    assign a_neg  = mdu_is_signed(op_i) & opa_i[WIDTH-1];
    assign b_neg  = mdu_is_signed(op_i) & opb_i[WIDTH-1];
    assign abs_a  = a_neg ? -opa_i : opa_i;
    assign abs_b  = b_neg ? -opb_i : opb_i;

    // Shift-add: low MUL_BITS of prod_q are the unconsumed multiplier bits.
    always_comb begin
        pp_sum = '0;
        for (int i = 0; i < MUL_BITS; i++) begin
            if (prod_q[i]) begin
                pp_sum = pp_sum + ({{MUL_BITS{1'b0}}, opa_q} << i);
            end
        end
        mul_hi   = {{MUL_BITS{1'b0}}, prod_q[2*WIDTH-1:WIDTH]} + pp_sum;
        mul_next = {mul_hi, prod_q[WIDTH-1:MUL_BITS]};
    end

    always_comb begin
        prod_signed = (sign_a_q ^ sign_b_q) ? -prod_q : prod_q;
        quot_signed = (sign_a_q ^ sign_b_q) ? -div_quot : div_quot;
        rem_signed  = sign_a_q ? -div_rem : div_rem;
        raw_a       = sign_a_q ? -opa_q : opa_q;
        case (op_q)
            MDU_OP_DIV, MDU_OP_DIVU:
                result = (opb_q == '0) ? {raw_a, {WIDTH{1'b1}}} : {rem_signed, quot_signed};
            MDU_OP_MADD, MDU_OP_MADDU: result = acc_q + prod_signed;
            MDU_OP_MSUB, MDU_OP_MSUBU: result = acc_q - prod_signed;
            default:                   result = prod_signed;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        acc_d    = acc_q;
        prod_d   = prod_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        div_load = 1'b0;
        div_step = 1'b0;
        case (state_q)
            MDU_ST_IDLE: begin
                if (accept) begin
                    op_d     = op_i;
                    opa_d    = abs_a;
                    opb_d    = abs_b;
                    sign_a_d = a_neg;
                    sign_b_d = b_neg;
                    acc_d    = {hi_i, lo_i};
                    prod_d   = {{WIDTH{1'b0}}, abs_b};
                    cnt_d    = '0;
                    div_load = 1'b1;
                    if (!mdu_is_div(op_i)) begin
                        state_d = MDU_ST_MUL;
                    end else if (opb_i == '0) begin
                        state_d = MDU_ST_FIX;
                    end else begin
                        state_d = MDU_ST_DIV;
                    end
                end
            end
            MDU_ST_MUL: begin
                if (annul_i) begin
                    state_d = MDU_ST_IDLE;
                end else begin
                    prod_d = mul_next;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == MUL_LAST) state_d = MDU_ST_FIX;
                end
            end
            MDU_ST_DIV: begin
                if (annul_i) begin
                    state_d = MDU_ST_IDLE;
                end else begin
                    div_step = 1'b1;
                    cnt_d    = cnt_q + 1'b1;
                    if (cnt_q == DIV_LAST) state_d = MDU_ST_FIX;
                end
            end
            default: begin
                // FIX always completes; annul here only gates the next accept.
                hi_d    = result[2*WIDTH-1:WIDTH];
                lo_d    = result[WIDTH-1:0];
                done_d  = 1'b1;
                state_d = MDU_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= MDU_ST_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            acc_q    <= '0;
            prod_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            acc_q    <= acc_d;
            prod_q   <= prod_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    mdu_div_core #(
        .WIDTH (WIDTH)
    ) u_div_core (
        .clk        (clk),
        .rst        (rst),
        .load_i     (div_load),
        .step_i     (div_step),
        .dividend_i (abs_a),
        .divisor_i  (opb_q),
        .rem_o      (div_rem),
        .quot_o     (div_quot)
    );

    assign done_o = done_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_ex_muldiv : directed vectors for ex_muldiv                      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_ex_muldiv;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic [2:0]  op_i = 3'd0;
    logic [31:0] opa_i = '0, opb_i = '0, hi_i = '0, lo_i = '0;
    logic        annul_i = 1'b0;
    logic        busy_o, done_o;
    logic [31:0] hi_o, lo_o;

    int vectors = 0;
    int miscompares = 0;
    int lat, busy_n, done_n;

    ex_muldiv #(.WIDTH(32), .MUL_BITS(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .start_i (start_i),
        .op_i    (op_i),
        .opa_i   (opa_i),
        .opb_i   (opb_i),
        .hi_i    (hi_i),
        .lo_i    (lo_i),
        .annul_i (annul_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .hi_o    (hi_o),
        .lo_o    (lo_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one op, then wait (bounded) for done_o; reports edges-to-done and busy cycles.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ah, input logic [31:0] al,
                          output int n_lat, output int n_busy);
        op_i = op; opa_i = a; opb_i = b; hi_i = ah; lo_i = al;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        n_lat = 0;
        n_busy = 0;
        while (n_lat < 100) begin
            if (busy_o) n_busy++;
            tick();
            n_lat++;
            if (done_o) break;
        end
    endtask

    initial begin
        tick(); tick();
        rst = 1'b0;
        tick();
        check("reset_busy", {63'd0, busy_o}, 64'd0);
        check("reset_done", {63'd0, done_o}, 64'd0);
        check("reset_hilo", {hi_o, lo_o}, 64'd0);

        run_op(3'd0, 32'hFFFFFFFD, 32'd5, 0, 0, lat, busy_n);
        check("mult_res", {hi_o, lo_o}, 64'hFFFFFFFF_FFFFFFF1);
        check("mult_lat", 64'(lat), 64'd17);
        check("mult_busy", 64'(busy_n), 64'd17);

        run_op(3'd2, 32'hFFFFFFF9, 32'd2, 0, 0, lat, busy_n);
        check("div_res", {hi_o, lo_o}, 64'hFFFFFFFF_FFFFFFFD);
        check("div_lat", 64'(lat), 64'd33);

        run_op(3'd3, 32'h00001234, 32'd0, 0, 0, lat, busy_n);
        check("divz_res", {hi_o, lo_o}, 64'h00001234_FFFFFFFF);
        check("divz_lat", 64'(lat), 64'd1);

        run_op(3'd6, 32'd3, 32'd4, 32'd0, 32'd10, lat, busy_n);
        check("msub_res", {hi_o, lo_o}, 64'hFFFFFFFF_FFFFFFFE);
        run_op(3'd5, 32'd1, 32'd1, 32'd0, 32'hFFFFFFFF, lat, busy_n);
        check("maddu_res", {hi_o, lo_o}, 64'h00000001_00000000);
        run_op(3'd4, 32'hFFFFFFFE, 32'd3, 32'd0, 32'd5, lat, busy_n);
        check("madd_res", {hi_o, lo_o}, 64'hFFFFFFFF_FFFFFFFF);

        run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 0, 0, lat, busy_n);
        check("div_minneg1", {hi_o, lo_o}, 64'h00000000_80000000);
        run_op(3'd2, 32'd7, 32'hFFFFFFFE, 0, 0, lat, busy_n);
        check("div_pos_neg", {hi_o, lo_o}, 64'h00000001_FFFFFFFD);
        run_op(3'd3, 32'd100, 32'd7, 0, 0, lat, busy_n);
        check("divu_res", {hi_o, lo_o}, 64'h00000002_0000000E);
        run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, lat, busy_n);
        check("multu_max", {hi_o, lo_o}, 64'hFFFFFFFE_00000001);

        // Annul a DIVU after five iterations.
        op_i = 3'd3; opa_i = 32'd100; opb_i = 32'd7; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (5) tick();
        annul_i = 1'b1;
        tick();
        annul_i = 1'b0;
        check("annul_busy", {63'd0, busy_o}, 64'd0);
        done_n = 0;
        for (int i = 0; i < 40; i++) begin
            if (done_o) done_n++;
            tick();
        end
        check("annul_nodone", 64'(done_n), 64'd0);
        check("annul_hilo", {hi_o, lo_o}, 64'hFFFFFFFE_00000001);

        run_op(3'd1, 32'd2, 32'd3, 0, 0, lat, busy_n);
        check("multu_2x3", {hi_o, lo_o}, 64'd6);
        check("b2b_done_now", {63'd0, done_o}, 64'd1);
        run_op(3'd1, 32'd5, 32'd6, 0, 0, lat, busy_n);
        check("b2b_res", {hi_o, lo_o}, 64'd30);
        check("b2b_lat", 64'(lat), 64'd17);

        // Start together with annul in IDLE is dropped.
        op_i = 3'd1; start_i = 1'b1; annul_i = 1'b1;
        tick();
        start_i = 1'b0; annul_i = 1'b0;
        check("annul_start_busy", {63'd0, busy_o}, 64'd0);

        // Async reset in the middle of a DIV.
        op_i = 3'd2; opa_i = 32'd100; opb_i = 32'd7; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (10) tick();
        #2 rst = 1'b1;
        #1;
        check("rst_busy", {63'd0, busy_o}, 64'd0);
        check("rst_done", {63'd0, done_o}, 64'd0);
        check("rst_hilo", {hi_o, lo_o}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
